// File: rtl/vliw_regfile_sb.sv
// Multi-port integer register file with a pending-write scoreboard for the VLIW datapath.
// Highest-index write port wins on collisions; x0 reads as zero and is never written or marked busy.
module vliw_regfile_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*XLEN-1:0]   rd,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     wa,
    input  logic [NWR*XLEN-1:0]   wd,
    input  logic [NWR-1:0]        iss,
    input  logic [NWR*AW-1:0]     issrd,
    output logic                  wconflict,
    output logic [NREG-1:0]       busyvec
);

    logic [XLEN-1:0] regs    [NREG];
    logic [XLEN-1:0] wr_data [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] iss_hit;
    logic            conflict_next;

    logic [AW-1:0]   rsel    [NRD];
    logic [XLEN-1:0] rdat    [NRD];
    logic [NRD-1:0]  byp_hit;

    // Per-register write selection: later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wr_hit[r]  = 1'b0;
            wr_data[r] = '0;
            iss_hit[r] = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (r != 0 && we[j] && wa[j*AW +: AW] == AW'(r)) begin
                    wr_hit[r]  = 1'b1;
                    wr_data[r] = wd[j*XLEN +: XLEN];
                end
                if (r != 0 && iss[j] && issrd[j*AW +: AW] == AW'(r)) begin
                    iss_hit[r] = 1'b1;
                end
            end
            // A new issue supersedes the completing producer, so issue beats write.
            busy_next[r] = iss_hit[r] | (busy[r] & ~wr_hit[r]);
        end
    end

    // Conflict detection depends only on enables and addresses, never on write data.
    always_comb begin
        conflict_next = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            for (int k = j + 1; k < NWR; k++) begin
                if (we[j] && we[k] && wa[j*AW +: AW] == wa[k*AW +: AW] &&
                    wa[j*AW +: AW] != '0) begin
                    conflict_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            busy      <= '0;
            wconflict <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_data[r];
                end
            end
            busy      <= busy_next;
            wconflict <= conflict_next;
        end
    end

    // Independent read mux per port, with optional forwarding of same-cycle writes.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            rsel[i]    = ra[i*AW +: AW];
            byp_hit[i] = 1'b0;
            rdat[i]    = regs[rsel[i]];
            for (int j = 0; j < NWR; j++) begin
                if (BYPASS != 0 && we[j] && wa[j*AW +: AW] == rsel[i]) begin
                    byp_hit[i] = 1'b1;
                    rdat[i]    = wd[j*XLEN +: XLEN];
                end
            end
            if (rsel[i] == '0) begin
                byp_hit[i] = 1'b0;
                rdat[i]    = '0;
            end
            rd[i*XLEN +: XLEN] = rdat[i];
            rbusy[i]           = busy[rsel[i]] & ~byp_hit[i];
        end
    end

    assign busyvec = busy;

endmodule
